// File: rtl/edge_pack_pkg.sv
// Shared types for the Sobel edge-pixel output packer.
// State encoding, lane geometry and the FIFO entry layout.
package edge_pack_pkg;

   localparam int PIX_PER_WORD = 4;
   localparam int LANE_W       = 8;
   localparam int WORD_W       = PIX_PER_WORD * LANE_W;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PACK,
      S_FLUSH,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0]       data;
      logic [PIX_PER_WORD-1:0] byte_en;
      logic                    last;
   } fifo_entry_t;

endpackage

// File: rtl/edge_out_packer_if.sv
// Packed-word output port: valid/ready handshake with lane mask
// and end-of-frame marker.
interface edge_out_packer_if;
   import edge_pack_pkg::*;

   logic [WORD_W-1:0]       word_out;
   logic [PIX_PER_WORD-1:0] byte_en;
   logic                    last_out;
   logic                    valid_out;
   logic                    ready_in;

   modport master (
      output word_out,
      output byte_en,
      output last_out,
      output valid_out,
      input  ready_in
   );

   modport slave (
      input  word_out,
      input  byte_en,
      input  last_out,
      input  valid_out,
      output ready_in
   );

endinterface

// File: rtl/edge_out_packer_pack_fifo.sv
// First-word-fall-through FIFO of packed words; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module pack_fifo
   import edge_pack_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_i,
   input  fifo_entry_t entry_i,
   input  logic        pop_i,
   output fifo_entry_t entry_o,
   output logic        full_o,
   output logic        empty_o,
   output logic [AW:0] level_o
);

   fifo_entry_t   mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d;
   logic [AW-1:0] rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign level_o = cnt_q;
   assign entry_o = mem_q[rd_q];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= entry_i;
   end

endmodule

// File: rtl/edge_out_packer.sv
// Packs 8-bit edge pixels four per word into a FWFT FIFO.
// Optional EDGE_STATS_EN adds an edge_count output.
module edge_out_packer
   import edge_pack_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 21,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [CNT_W-1:0]   total_pixel,
   input  logic [LANE_W-1:0]  pixel_in,
   input  logic               valid_in,
   edge_out_packer_if.master  out_if,
   output logic               frame_done,
   output logic               overflow,
   output logic [LVL_W-1:0]   fifo_level
`ifdef EDGE_STATS_EN
   ,
   output logic [CNT_W-1:0]   edge_count
`endif
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   total_q;
   logic [CNT_W-1:0]   pix_cnt_q;
   logic [LANE_W-1:0]  lane_q [PIX_PER_WORD];
   fifo_entry_t        stg_q;
   logic               stg_vld_q;
   logic               ovf_q;
   logic               done_q;

   logic               go;
   logic               accept;
   logic               done_d;
   logic               last_px;
   logic               complete;
   logic [1:0]         lane;
   fifo_entry_t        ent_d;

   fifo_entry_t        head;
   logic               fifo_full;
   logic               fifo_empty;
   logic               pop;

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start)
               state_d = (total_pixel == '0) ? S_DONE : S_PACK;
         end
         S_PACK: begin
            if (last_px) state_d = S_FLUSH;
         end
         S_FLUSH: begin
            if (!stg_vld_q && fifo_empty) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      go     = (state_q == S_IDLE) & start;
      accept = (state_q == S_PACK) & valid_in;
      done_d = (state_q == S_DONE);
   end

   assign lane     = pix_cnt_q[1:0];
   assign last_px  = accept & (pix_cnt_q == total_q - 1'b1);
   assign complete = accept & ((lane == 2'd3) | last_px);

   // Earlier lanes come from the register, the current one from the
   // input; lanes above the current one stay zero.
   always_comb begin
      ent_d = '0;
      for (int k = 0; k < PIX_PER_WORD - 1; k++) begin
         if (2'(k) < lane) ent_d.data[k*LANE_W +: LANE_W] = lane_q[k];
      end
      ent_d.data[{lane, 3'b000} +: LANE_W] = pixel_in;
      for (int k = 0; k < PIX_PER_WORD; k++) begin
         ent_d.byte_en[k] = (2'(k) <= lane);
      end
      ent_d.last = last_px;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         total_q   <= '0;
         pix_cnt_q <= '0;
         for (int k = 0; k < PIX_PER_WORD; k++) lane_q[k] <= '0;
         stg_q     <= '0;
         stg_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= done_d;
         stg_vld_q <= complete;
         if (complete) stg_q <= ent_d;
         if (go) begin
            total_q   <= total_pixel;
            pix_cnt_q <= '0;
            for (int k = 0; k < PIX_PER_WORD; k++) lane_q[k] <= '0;
            ovf_q     <= 1'b0;
         end else begin
            if (accept) begin
               pix_cnt_q    <= pix_cnt_q + 1'b1;
               lane_q[lane] <= pixel_in;
            end
            if (stg_vld_q && fifo_full && !pop) ovf_q <= 1'b1;
         end
      end
   end

`ifdef EDGE_STATS_EN
   logic [CNT_W-1:0] edge_cnt_q;

   always_ff @(posedge clk) begin
      if (reset)                            edge_cnt_q <= '0;
      else if (go)                          edge_cnt_q <= '0;
      else if (accept && pixel_in != '0)    edge_cnt_q <= edge_cnt_q + 1'b1;
   end

   assign edge_count = edge_cnt_q;
`endif

   assign pop = out_if.valid_out & out_if.ready_in;

   pack_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (stg_vld_q),
      .entry_i (stg_q),
      .pop_i   (pop),
      .entry_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // Gate the head with empty so unwritten storage never leaks out.
   assign out_if.valid_out = ~fifo_empty;
   assign out_if.word_out  = fifo_empty ? '0 : head.data;
   assign out_if.byte_en   = fifo_empty ? '0 : head.byte_en;
   assign out_if.last_out  = fifo_empty ? 1'b0 : head.last;

   assign frame_done = done_q;
   assign overflow   = ovf_q;

endmodule
